bin2onehot_led: RTL
===================

BIN2ONEHOT_LED -- requirements
Module: bin2onehot_led

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000: clk cycles a decoded LED pattern is displayed; legal range 2..2^24-1.
REQ-002 Parameter BLINK_CYCLES, default 100: half-period of blink in clk cycles; used only when BIN2ONEHOT_BLINK_EN is defined; legal range 1..HOLD_CYCLES.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  in_idx carries a request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_idx  input  5  binary switch number; 1..18 are legal, 0 means "all off".
REQ-008 led  output  18  one-hot LED pattern, registered.
REQ-009 busy  output  1  high while a pattern is being held.
REQ-010 err  output  1  one-cycle pulse on acceptance of an illegal index.

Function
REQ-011 Transfer occurs on a rising edge with in_valid=1 and in_ready=1; no other cycle changes state from the input side.
REQ-012 FSM states: IDLE, HOLD, GAP; in_ready=1 only in IDLE; busy=1 in HOLD and GAP.
REQ-013 IDLE + transfer, in_idx=k with 1<=k<=18 -> next cycle led[k-1]=1, all other bits 0, state HOLD, counter loaded with HOLD_CYCLES-1.
REQ-014 IDLE + transfer, in_idx=0 -> led=0, state HOLD with the same timing as REQ-013; err stays 0.
REQ-015 IDLE + transfer, in_idx in 19..31 -> led=0, err=1 for exactly the next cycle, state stays IDLE; no hold time is applied.
REQ-016 Mapping is dense and strictly sequential: every index 1..18 maps to exactly one distinct LED bit; no bit position is skipped.
REQ-017 HOLD: counter decrements every cycle; when it reaches 0 the next state is GAP, giving exactly HOLD_CYCLES cycles of pattern.
REQ-018 GAP lasts exactly one cycle with led=0, then the next state is IDLE; this makes back-to-back identical indices visible.
REQ-019 in_valid while in_ready=0 is ignored; the source must hold in_valid and in_idx stable until the transfer occurs.
REQ-020 Latency: the first cycle of led at its new value is the cycle after the transfer; end-to-end request spacing is HOLD_CYCLES+2 cycles.
REQ-021 Counter width is $clog2(HOLD_CYCLES); no wrap-around is permitted; the counter saturates at 0.

Reset
REQ-022 rst=1 at any clock edge -> state IDLE, led=0, err=0, busy=0, in_ready=1 on the next cycle, counter=0.
REQ-023 rst asserted mid-HOLD or mid-GAP aborts the display immediately; a request presented in the same cycle as rst is dropped.

Configuration
REQ-024 Macro BIN2ONEHOT_BLINK_EN defined: in HOLD the lit bit toggles every BLINK_CYCLES cycles, starting lit; the other bits stay 0; hold length is unchanged.
REQ-025 Macro BIN2ONEHOT_BLINK_EN undefined: the lit bit is steady for the full hold; no blink counter or register is synthesized.

Structure
REQ-026 Package bin2onehot_pkg holds: NUM_LEDS=18, IDX_W=5, IDX_OFF=0, and the FSM state enumeration (IDLE, HOLD, GAP).
REQ-027 One sub-module, hold_timer: a loadable down-counter with a zero flag, instanced once for hold and, under BIN2ONEHOT_BLINK_EN, once for blink.

Verification
REQ-028 Reset, then in_idx=1 for one cycle with valid -> led=18'h00001 for 1000 cycles, one cycle of 0, then in_ready=1.
REQ-029 Sweep idx 1..18 back-to-back -> led equals 1<<(k-1) for each k, including led[9] for k=10; each pattern lasts 1000 cycles.
REQ-030 in_idx=25 -> led=0, err high for exactly 1 cycle, in_ready stays 1, busy stays 0.
REQ-031 idx=5, then idx=7 presented at hold cycle 300 -> in_ready=0 and idx 7 is not accepted until IDLE; led=18'h00010 is uninterrupted.
REQ-032 idx=18, rst pulsed at hold cycle 500 -> next cycle led=0, state IDLE; same-cycle request is dropped.
REQ-033 With BIN2ONEHOT_BLINK_EN, BLINK_CYCLES=100, idx=3 -> led[2] is lit during cycles 0-99, dark during 100-199, and so on, and the pattern ends after 1000 cycles.

Source files
------------

// File: rtl/bin2onehot_pkg.sv
// Shared constants, FSM state type and index decode helpers for bin2onehot_led.
package bin2onehot_pkg;

  localparam int unsigned NUM_LEDS = 18;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned IDX_OFF  = 0;

  // Largest index that still maps to an LED; 0 is also legal ("all off").
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_LEDS);

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Hold = 2'd1,
    Gap  = 2'd2
  } state_e;

  // Index k (1..NUM_LEDS) lights bit k-1+IDX_OFF; anything else decodes to all-off.
  function automatic logic [NUM_LEDS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_LEDS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      oh[i] = (idx == IDX_W'(i + 1 - IDX_OFF));
    end
    return oh;
  endfunction

  function automatic logic idx_is_legal(input logic [IDX_W-1:0] idx);
    return (idx <= IDX_MAX);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that saturates at zero and flags when it sits at zero.
module hold_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bin2onehot_led.sv
// Binary switch index to one-hot LED display with fixed hold time and a one-cycle gap.
// Optional blinking of the lit LED during hold when BIN2ONEHOT_BLINK_EN is defined.
module bin2onehot_led
  import bin2onehot_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 1000,
  parameter int unsigned BLINK_CYCLES = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IDX_W-1:0]    in_idx,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy,
  output logic                err
);

  if ((HOLD_CYCLES < 2) || (HOLD_CYCLES > 32'd16777215)) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 2..2^24-1");
  end
  if ((BLINK_CYCLES < 1) || (BLINK_CYCLES > HOLD_CYCLES)) begin : g_bad_blink
    $error("BLINK_CYCLES must be in 1..HOLD_CYCLES");
  end

  localparam int unsigned      HoldW    = $clog2(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                err_q, err_d;
  logic                xfer;
  logic                idx_legal;
  logic                in_hold;
  logic                hold_load;
  logic                hold_zero;

  assign xfer      = in_valid && (state_q == Idle);
  assign idx_legal = idx_is_legal(in_idx);
  assign in_hold   = (state_q == Hold);
  assign hold_load = xfer && idx_legal;

  hold_timer #(
    .Width(HoldW)
  ) u_hold_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (hold_load),
    .load_val_i(HoldLoad),
    .dec_i     (in_hold),
    .zero_o    (hold_zero)
  );

`ifdef BIN2ONEHOT_BLINK_EN
  localparam int unsigned       BlinkW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BlinkW-1:0] BlinkLoad = BlinkW'(BLINK_CYCLES - 1);

  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic                blink_on_q, blink_on_d;
  logic                blink_zero;
  logic                blink_load;

  // The blink timer re-arms itself each time a half-period expires.
  assign blink_load = hold_load || (in_hold && blink_zero);

  hold_timer #(
    .Width(BlinkW)
  ) u_blink_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (blink_load),
    .load_val_i(BlinkLoad),
    .dec_i     (in_hold),
    .zero_o    (blink_zero)
  );

  always_comb begin
    pat_d      = pat_q;
    blink_on_d = blink_on_q;
    if (hold_load) begin
      pat_d      = idx_to_onehot(in_idx);
      blink_on_d = 1'b1;
    end else if (in_hold && blink_zero) begin
      blink_on_d = ~blink_on_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q      <= '0;
      blink_on_q <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      blink_on_q <= blink_on_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Idle;
      led_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  // Illegal indices never leave Idle, so no hold time is spent on them.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle: begin
        if (hold_load) begin
          state_d = Hold;
        end
      end
      Hold: begin
        if (hold_zero) begin
          state_d = Gap;
        end
      end
      Gap:     state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == Idle);
    busy     = (state_q == Hold) || (state_q == Gap);
    err_d    = xfer && !idx_legal;
    led_d    = led_q;
    unique case (state_q)
      Idle: begin
        if (xfer) begin
          led_d = idx_to_onehot(in_idx);
        end
      end
      Hold: begin
        if (hold_zero) begin
          led_d = '0;
        end else begin
`ifdef BIN2ONEHOT_BLINK_EN
          led_d = pat_q & {NUM_LEDS{blink_on_d}};
`else
          led_d = led_q;
`endif
        end
      end
      Gap:     led_d = '0;
      default: led_d = '0;
    endcase
  end

  assign led = led_q;
  assign err = err_q;

endmodule
